alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Upstream/downstream wrapper stage around the 32-bit ALU.
- Buffers operation commands (A, B, opcode, tag) from the decode/sequencer side and issues at most one per cycle to the ALU's A/B/Opin inputs.
- Captures the ALU's result/zero after a fixed latency into an in-order response FIFO.
- Credit-based issue: responses are never dropped, even under downstream backpressure.

Parameters:
- CDEPTH, 4, command FIFO entries (power of 2, ≥2).
- RDEPTH, 4, response FIFO entries (power of 2, ≥2); also the maximum ops in flight plus buffered.
- ALU_LATENCY, 1, cycles from an issue edge to a valid alu_result/alu_zero (1..4).
- TAGW, 4, tag width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command FIFO can accept.
- cmd_a  in  32  operand A.
- cmd_b  in  32  operand B.
- cmd_op  in  4  ALU opcode.
- cmd_tag  in  TAGW  caller tag, returned with the response.
- alu_A  out  32  registered operand A to the ALU.
- alu_B  out  32  registered operand B to the ALU.
- alu_Opin  out  4  registered opcode to the ALU.
- alu_result  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  32  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_tag  out  TAGW  tag of the response.
- rsp_err  out  1  illegal opcode flag (tied 0 unless ALU_OPCHECK_EN is defined).

Behaviour:
- Reset (synchronous, sampled at a rising clk edge while reset=1):
  - Both FIFOs are emptied and all in-flight ops are discarded.
  - rsp_valid=0; alu_A=0, alu_B=0, alu_Opin=0; rsp_result/zero/tag/err=0.
  - cmd_ready=0 during the reset cycle.
  - A reset mid-operation drops everything; no response emerges for commands accepted before reset.
- Command accept: a transfer occurs on an edge with cmd_valid & cmd_ready.
  - cmd_ready = !reset & (cmd_count < CDEPTH).
  - Full FIFO with a simultaneous issue still reports cmd_ready=0; no same-cycle pass-through credit.
- Issue condition: cmd FIFO non-empty and credit = inflight + rsp_count < RDEPTH.
  - On issue, the head entry is popped and registered into alu_A/alu_B/alu_Opin.
  - Its tag is pushed into an ALU_LATENCY-deep valid/tag shift pipe.
  - Max one issue per cycle.
  - When not issuing, alu_A/B/Opin hold their previous values.
  - A command accepted into an empty FIFO issues at the earliest on the next edge: 1-cycle accept-to-issue latency.
- Capture: when the pipe's last stage is valid, alu_result/alu_zero/tag are pushed into the response FIFO on that edge.
  - Credit guarantees space, so the FIFO never overflows.
  - inflight counts valid pipe stages; the counter is updated for simultaneous issue and capture.
- Response: rsp_* present the response FIFO head.
  - rsp_valid = rsp_count != 0; the head pops on rsp_valid & rsp_ready.
  - Push and pop in the same cycle leave rsp_count unchanged.
  - Order is strictly FIFO; tags are returned in issue order.
- Throughput: 1 op/cycle sustained when rsp_ready=1.
  - Minimum cmd-accept-to-rsp_valid latency = 1 + ALU_LATENCY + 1 cycles.
- Pointers wrap modulo depth. Counts are $clog2(depth)+1 bits wide.

Optional Feature:
- Macro ALU_OPCHECK_EN.
- Defined: legal opcodes are {0000,0010,0100,0111,1010}. An illegal cmd_op still consumes an issue slot and a credit, but alu_A/B/Opin are not updated. Its pipe entry carries err=1, and the captured response has result=0, zero=0, rsp_err=1, with order preserved.
- Undefined: all opcodes pass through unchanged and rsp_err is tied 0.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams (OP_0000, OP_0010, OP_0100, OP_0111, OP_1010);
  - the data width 32;
  - the legal-opcode check function.
- One natural sub-module, sync_fifo (parameter WIDTH, DEPTH), instantiated twice: command FIFO of width 32+32+4+TAGW, response FIFO of width 32+1+TAGW+1.

Test Plan:
- Reset: hold reset 2 cycles with cmd_valid=1 → cmd_ready=0, rsp_valid=0, alu_A/B/Opin=0. Release → cmd_ready=1 on the next cycle.
- Single op: A=0x1B, B=0x2E, op=0100, tag=3, ALU_LATENCY=1.
  - alu_A=0x1B, alu_Opin=0100 one cycle after accept.
  - rsp_valid with rsp_tag=3 and rsp_result equal to the ALU output 3 cycles after accept.
- Streaming: ops 0000,0100,0111,0010,1010 with tags 0..4, one per cycle, rsp_ready=1 → five responses on consecutive cycles, tags 0,1,2,3,4.
- Backpressure: rsp_ready=0, push 10 cmds →
  - exactly 4 responses buffered;
  - cmd FIFO fills to 4 and cmd_ready drops;
  - no loss: after rsp_ready=1, all 10 tags arrive in order.
- Mid-flight reset: issue 3 ops, assert reset 1 cycle before the first capture → no responses; rsp_valid stays 0 for 10 cycles.
- ALU_OPCHECK_EN: op=1111, tag=7 between two legal ops → alu_Opin unchanged for that slot. The middle response has tag=7, rsp_err=1, result=0, zero=0, and order is preserved.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU data width, opcode constants and legal-opcode check.
package alu_pkg;
   localparam int DW = 32;
   localparam logic [3:0] OP_0000 = 4'b0000;
   localparam logic [3:0] OP_0010 = 4'b0010;
   localparam logic [3:0] OP_0100 = 4'b0100;
   localparam logic [3:0] OP_0111 = 4'b0111;
   localparam logic [3:0] OP_1010 = 4'b1010;

   function automatic logic op_legal(input logic [3:0] op);
      return (op == OP_0000) || (op == OP_0010) || (op == OP_0100) ||
             (op == OP_0111) || (op == OP_1010);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO; dout reads zero while empty so an idle FIFO presents clean outputs.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CNW = AW + 1;
   localparam logic [AW:0] CMAX = CNW'(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic do_push, do_pop;
   assign do_pop = pop && (count != '0);
   assign do_push = push && (count < CMAX);
   assign dout = (count != '0) ? mem[rd] : '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wr] <= din;
            wr <= wr + 1'b1;
         end
         if (do_pop) rd <= rd + 1'b1;
         count <= count + CNW'(do_push) - CNW'(do_pop);
      end
   end
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: credit-based command/response wrapper around the 32-bit ALU.
// Optional ALU_OPCHECK_EN: illegal opcodes are not issued to the ALU and return rsp_err=1.
module alu_issue_queue
   import alu_pkg::*;
#(
   parameter int CDEPTH = 4,
   parameter int RDEPTH = 4,
   parameter int ALU_LATENCY = 1,
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [DW-1:0]   cmd_a,
   input  logic [DW-1:0]   cmd_b,
   input  logic [3:0]      cmd_op,
   input  logic [TAGW-1:0] cmd_tag,
   output logic [DW-1:0]   alu_A,
   output logic [DW-1:0]   alu_B,
   output logic [3:0]      alu_Opin,
   input  logic [DW-1:0]   alu_result,
   input  logic            alu_zero,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_result,
   output logic            rsp_zero,
   output logic [TAGW-1:0] rsp_tag,
   output logic            rsp_err
);
   localparam int CW = $clog2(CDEPTH) + 1;
   localparam int RW = $clog2(RDEPTH) + 1;
   // The result is valid ALU_LATENCY cycles after the issue edge and is sampled on the following edge.
   localparam int PD = ALU_LATENCY + 1;
   localparam int IW = $clog2(PD + 1);
   localparam int CFW = 2 * DW + 4 + TAGW;
   localparam int RFW = DW + 1 + TAGW + 1;
   localparam int SW = RW + 1;
   logic [CW-1:0] cmd_count;
   logic [RW-1:0] rsp_count;
   logic [CFW-1:0] cmd_head;
   logic [RFW-1:0] rsp_din, rsp_head;
   logic [DW-1:0] head_a, head_b;
   logic [3:0] head_op;
   logic [TAGW-1:0] head_tag;
   logic head_err, issue, capture;
   logic [PD-1:0] pv, pe;
   logic [TAGW-1:0] pt [PD];
   logic [IW-1:0] inflight;
   logic [RW:0] credit;

   assign cmd_ready = !reset && (cmd_count < CW'(CDEPTH));
   assign {head_a, head_b, head_op, head_tag} = cmd_head;
`ifdef ALU_OPCHECK_EN
   assign head_err = !op_legal(head_op);
`else
   assign head_err = 1'b0;
`endif
   assign credit = SW'(inflight) + SW'(rsp_count);
   assign issue = (cmd_count != '0) && (credit < SW'(RDEPTH));
   assign capture = pv[PD-1];
   assign rsp_din = pe[PD-1] ? {{DW{1'b0}}, 1'b0, pt[PD-1], 1'b1}
                             : {alu_result, alu_zero, pt[PD-1], 1'b0};
   assign rsp_valid = rsp_count != '0;
   assign {rsp_result, rsp_zero, rsp_tag, rsp_err} = rsp_head;

   sync_fifo #(.WIDTH(CFW), .DEPTH(CDEPTH)) u_cmd (
      .clk(clk), .reset(reset), .push(cmd_valid && cmd_ready), .pop(issue),
      .din({cmd_a, cmd_b, cmd_op, cmd_tag}), .dout(cmd_head), .count(cmd_count)
   );

   sync_fifo #(.WIDTH(RFW), .DEPTH(RDEPTH)) u_rsp (
      .clk(clk), .reset(reset), .push(capture), .pop(rsp_ready),
      .din(rsp_din), .dout(rsp_head), .count(rsp_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_A <= '0;
         alu_B <= '0;
         alu_Opin <= '0;
         pv <= '0;
         pe <= '0;
         inflight <= '0;
      end else begin
         if (issue && !head_err) begin
            alu_A <= head_a;
            alu_B <= head_b;
            alu_Opin <= head_op;
         end
         pv <= {pv[PD-2:0], issue};
         pe <= {pe[PD-2:0], issue && head_err};
         inflight <= inflight + IW'(issue) - IW'(capture);
      end
   end

   always_ff @(posedge clk) begin
      pt[0] <= head_tag;
      for (int i = 1; i < PD; i++) pt[i] <= pt[i-1];
   end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: self-checking bench with a latency-L behavioural ALU and a response scoreboard.
module tb_alu_issue_queue;
   localparam int L = 1;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [3:0]  tag;
      logic [31:0] res;
      logic        zero;
   } vec_t;
   typedef struct packed {
      logic [31:0] res;
      logic        zero;
      logic [3:0]  tag;
      logic        err;
   } rsp_t;

   logic clk = 1'b0, reset = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [31:0] cmd_a = '0, cmd_b = '0;
   logic [3:0] cmd_op = '0, cmd_tag = '0;
   logic [31:0] alu_A, alu_B, alu_result;
   logic [3:0] alu_Opin;
   logic alu_zero;
   logic rsp_valid, rsp_ready = 1'b0, rsp_zero, rsp_err;
   logic [31:0] rsp_result;
   logic [3:0] rsp_tag;
   logic [31:0] ap [L];

   int checks = 0, errors = 0, cyc = 0;
   int pop_cyc[$];
   rsp_t exp_q[$];
   bit rand_rr = 0;
   vec_t tbl [5];

   always #5 clk = ~clk;

   alu_issue_queue #(.CDEPTH(4), .RDEPTH(4), .ALU_LATENCY(L), .TAGW(4)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
      .alu_A(alu_A), .alu_B(alu_B), .alu_Opin(alu_Opin),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
   );

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      case (op)
         4'b0000: return a & b;
         4'b0010: return a + b;
         4'b0100: return a | b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1010: return a - b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [3:0] tag);
      logic [31:0] r;
`ifdef ALU_OPCHECK_EN
      if (!(op inside {4'b0000, 4'b0010, 4'b0100, 4'b0111, 4'b1010})) return '{32'd0, 1'b0, tag, 1'b1};
`endif
      r = alu_f(a, b, op);
      return '{r, r == 32'd0, tag, 1'b0};
   endfunction

   // Behavioural ALU whose output is registered L times after its inputs.
   always @(posedge clk) begin
      ap[0] <= alu_f(alu_A, alu_B, alu_Opin);
      for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
   end
   assign alu_result = ap[L-1];
   assign alu_zero = alu_result == 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got tag %0h, expected no response", rsp_tag);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            chk("rsp_result", 64'(rsp_result), 64'(e.res));
            chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            pop_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rr) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic try_send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [3:0] tag,
                           input rsp_t e, input int maxc, output bit ok);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < maxc && !ok; i++) begin
         if (cmd_ready) begin
            ok = 1;
            exp_q.push_back(e);
         end
         tick();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [3:0] tag);
      bit ok;
      try_send(a, b, op, tag, model(a, b, op, tag), 50, ok);
      chk("send_accept", 64'(ok), 64'd1);
   endtask

   task automatic drain(input int maxc);
      for (int i = 0; i < maxc && exp_q.size() != 0; i++) tick();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int n0;
      bit ok;
      logic [31:0] ra, rb;
      logic [3:0] rop;
      tbl[0] = '{32'h000000F0, 32'h0000003C, 4'b0000, 4'd0, 32'h00000030, 1'b0};
      tbl[1] = '{32'h0000001B, 32'h0000002E, 4'b0100, 4'd1, 32'h0000003F, 1'b0};
      tbl[2] = '{32'd5,        32'd9,        4'b0111, 4'd2, 32'd1,        1'b0};
      tbl[3] = '{32'hFFFFFFFF, 32'd1,        4'b0010, 4'd3, 32'd0,        1'b1};
      tbl[4] = '{32'd10,       32'd3,        4'b1010, 4'd4, 32'd7,        1'b0};

      // Reset held two cycles with a command offered.
      reset = 1'b1; cmd_valid = 1'b1; cmd_a = 32'h1234; cmd_b = 32'h5678; cmd_op = 4'b0010; cmd_tag = 4'd9;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
         chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("rst_alu_A", 64'(alu_A), 64'd0);
         chk("rst_alu_B", 64'(alu_B), 64'd0);
         chk("rst_alu_Opin", 64'(alu_Opin), 64'd0);
         chk("rst_rsp_fields", 64'({rsp_result, rsp_zero, rsp_tag, rsp_err}), 64'd0);
      end
      reset = 1'b0; cmd_valid = 1'b0;
      tick();
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

      // Single op: issue one cycle after accept, response three cycles after accept.
      cmd_a = 32'h1B; cmd_b = 32'h2E; cmd_op = 4'b0100; cmd_tag = 4'd3; cmd_valid = 1'b1;
      chk("single_ready", 64'(cmd_ready), 64'd1);
      exp_q.push_back('{32'h3F, 1'b0, 4'd3, 1'b0});
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("single_alu_A", 64'(alu_A), 64'h1B);
      chk("single_alu_B", 64'(alu_B), 64'h2E);
      chk("single_alu_Opin", 64'(alu_Opin), 64'b0100);
      chk("single_rsp_early1", 64'(rsp_valid), 64'd0);
      tick();
      chk("single_rsp_early2", 64'(rsp_valid), 64'd0);
      tick();
      chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("single_rsp_tag", 64'(rsp_tag), 64'd3);
      chk("single_rsp_result", 64'(rsp_result), 64'h3F);
      rsp_ready = 1'b1;
      tick();
      chk("single_rsp_popped", 64'(rsp_valid), 64'd0);

      // Streaming table: one command per cycle, responses on consecutive cycles.
      n0 = pop_cyc.size();
      for (int i = 0; i < 5; i++) begin
         try_send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag, '{tbl[i].res, tbl[i].zero, tbl[i].tag, 1'b0}, 1, ok);
         chk("stream_accept", 64'(ok), 64'd1);
      end
      drain(20);
      chk("stream_count", 64'(pop_cyc.size() - n0), 64'd5);
      for (int i = 1; i < 5 && n0 + i < pop_cyc.size(); i++)
         chk("stream_back_to_back", 64'(pop_cyc[n0+i] - pop_cyc[n0]), 64'(i));

      // Backpressure: 4 responses + 4 queued commands, then the ninth is refused.
      rsp_ready = 1'b0;
      for (int i = 0; i < 8; i++) send($urandom, $urandom, 4'(i % 3 * 2), 4'(i));
      try_send(32'd1, 32'd2, 4'b0010, 4'd8, model(32'd1, 32'd2, 4'b0010, 4'd8), 10, ok);
      chk("bp_reject", 64'(ok), 64'd0);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_head_tag", 64'(rsp_tag), 64'd0);
      rsp_ready = 1'b1;
      send(32'd1, 32'd2, 4'b0010, 4'd8);
      send(32'd40, 32'd2, 4'b1010, 4'd9);
      drain(50);

      // Reset while three ops are in flight: everything is dropped.
      for (int i = 0; i < 3; i++) send($urandom, $urandom, 4'b0010, 4'(10 + i));
      reset = 1'b1;
      exp_q.delete();
      tick();
      reset = 1'b0;
      chk("midrst_alu_A", 64'(alu_A), 64'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      end

`ifdef ALU_OPCHECK_EN
      // Illegal opcode between two legal ones: ALU inputs hold, error response in order.
      send(32'd1, 32'd2, 4'b0010, 4'd5);
      send(32'hAA, 32'hBB, 4'b1111, 4'd7);
      send(32'd8, 32'd3, 4'b0100, 4'd6);
      chk("opchk_hold_Opin", 64'(alu_Opin), 64'b0010);
      chk("opchk_hold_A", 64'(alu_A), 64'd1);
      drain(20);
`endif

      // Random traffic with random consumer backpressure against the scoreboard.
      rand_rr = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         else begin
            ra = $urandom; rb = ($urandom_range(0, 3) == 0) ? ra : $urandom; rop = 4'($urandom_range(0, 15));
            try_send(ra, rb, rop, 4'(i), model(ra, rb, rop, 4'(i)), 100, ok);
            chk("rand_accept", 64'(ok), 64'd1);
         end
      end
      rand_rr = 0;
      rsp_ready = 1'b1;
      drain(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
